// File: rtl/nf10_axis_pkt_replay.sv
// AXI4-Stream replay master: streams a preloaded beat program N times or continuously, with an inter-packet gap.
// Latency: first beat is valid the cycle after an accepted start. Backpressure: beats are held stable until tready.
module nf10_axis_pkt_replay #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_DEPTH              = 64,
    parameter int C_GAP_WIDTH          = 16,
    parameter int C_REPEAT_WIDTH       = 16,
    localparam int AW = $clog2(C_DEPTH),
    localparam int DW = C_M_AXIS_DATA_WIDTH,
    localparam int SW = C_M_AXIS_DATA_WIDTH / 8,
    localparam int UW = C_M_AXIS_TUSER_WIDTH,
    localparam int GW = C_GAP_WIDTH,
    localparam int RW = C_REPEAT_WIDTH
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          mem_wr_en,
    input  logic [AW-1:0] mem_wr_addr,
    input  logic [DW-1:0] mem_wr_data,
    input  logic [SW-1:0] mem_wr_strb,
    input  logic [UW-1:0] mem_wr_user,
    input  logic          mem_wr_last,
    input  logic [AW:0]   cfg_len,
    input  logic [RW-1:0] cfg_repeat,
    input  logic [GW-1:0] cfg_gap,
    input  logic          cfg_start,
    input  logic          cfg_stop,
    output logic [DW-1:0] m_axis_tdata,
    output logic [SW-1:0] m_axis_tstrb,
    output logic [UW-1:0] m_axis_tuser,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
    output logic          busy,
    output logic          done,
    output logic [31:0]   pkt_count
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t        state;
    logic [DW-1:0] mem_data [C_DEPTH];
    logic [SW-1:0] mem_strb [C_DEPTH];
    logic [UW-1:0] mem_user [C_DEPTH];
    logic          mem_last [C_DEPTH];

    logic [AW:0]   len_q;
    logic [RW-1:0] rep_q;
    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_cnt;
    logic [AW-1:0] rd_ptr;
    logic          stop_pend;

    logic          start_ok;
    logic          hs;
    logic          is_final;
    logic          stop_now;
    logic [AW-1:0] next_ptr;
    logic [AW-1:0] load_idx;
    logic [AW:0]   ld_len;
    logic          ld_last;

    always_ff @(posedge aclk) begin
        if (mem_wr_en && !busy) begin
            mem_data[mem_wr_addr] <= mem_wr_data;
            mem_strb[mem_wr_addr] <= mem_wr_strb;
            mem_user[mem_wr_addr] <= mem_wr_user;
            mem_last[mem_wr_addr] <= mem_wr_last;
        end
    end

    assign start_ok = cfg_start && (cfg_len != '0) && (cfg_len <= (AW+1)'(C_DEPTH));
    assign hs       = m_axis_tvalid && m_axis_tready;
    assign is_final = ({1'b0, rd_ptr} == len_q - 1'b1);
    assign next_ptr = is_final ? '0 : rd_ptr + 1'b1;
    assign stop_now = stop_pend || cfg_stop;

    always_comb begin
        load_idx = '0;
        ld_len   = len_q;
        case (state)
            S_IDLE:  ld_len   = cfg_len;
            S_SEND:  load_idx = next_ptr;
            S_GAP:   load_idx = rd_ptr;
            default: ;
        endcase
    end

    // The final beat of the program always closes a packet, whatever its stored tlast.
    assign ld_last = mem_last[load_idx] || ({1'b0, load_idx} == ld_len - 1'b1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pkt_count     <= '0;
            len_q         <= '0;
            rep_q         <= '0;
            gap_q         <= '0;
            gap_cnt       <= '0;
            rd_ptr        <= '0;
            stop_pend     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cfg_stop && busy) stop_pend <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        len_q         <= cfg_len;
                        rep_q         <= cfg_repeat;
                        gap_q         <= cfg_gap;
                        pkt_count     <= '0;
                        rd_ptr        <= '0;
                        busy          <= 1'b1;
                        m_axis_tdata  <= mem_data[load_idx];
                        m_axis_tstrb  <= mem_strb[load_idx];
                        m_axis_tuser  <= mem_user[load_idx];
                        m_axis_tlast  <= ld_last;
                        m_axis_tvalid <= 1'b1;
                        state         <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (hs) begin
                        if (m_axis_tlast) pkt_count <= pkt_count + 32'd1;
                        rd_ptr <= next_ptr;
                        if (is_final && rep_q != '0) rep_q <= rep_q - RW'(1);
                        if ((is_final && rep_q == RW'(1)) || (m_axis_tlast && stop_now)) begin
                            m_axis_tvalid <= 1'b0;
                            done          <= 1'b1;
                            state         <= S_DONE;
                        end else if (m_axis_tlast && gap_q != '0) begin
                            m_axis_tvalid <= 1'b0;
                            gap_cnt       <= gap_q;
                            state         <= S_GAP;
                        end else begin
                            m_axis_tdata <= mem_data[load_idx];
                            m_axis_tstrb <= mem_strb[load_idx];
                            m_axis_tuser <= mem_user[load_idx];
                            m_axis_tlast <= ld_last;
                        end
                    end
                end
                S_GAP: begin
                    if (stop_now) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (gap_cnt == GW'(1)) begin
                        m_axis_tdata  <= mem_data[load_idx];
                        m_axis_tstrb  <= mem_strb[load_idx];
                        m_axis_tuser  <= mem_user[load_idx];
                        m_axis_tlast  <= ld_last;
                        m_axis_tvalid <= 1'b1;
                        state         <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    stop_pend <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nf10_axis_pkt_replay.sv
// Bench for nf10_axis_pkt_replay: a program-level model queues expected beats; a monitor pops and compares on each handshake.
module tb_nf10_axis_pkt_replay;
    localparam int DW = 256, UW = 128, SW = 32, DEPTH = 64, AW = 6, GW = 16, RW = 16;

    logic          aclk = 1'b0, aresetn = 1'b0;
    logic          mem_wr_en = 1'b0, mem_wr_last = 1'b0;
    logic [AW-1:0] mem_wr_addr = '0;
    logic [DW-1:0] mem_wr_data = '0;
    logic [SW-1:0] mem_wr_strb = '0;
    logic [UW-1:0] mem_wr_user = '0;
    logic [AW:0]   cfg_len = '0;
    logic [RW-1:0] cfg_repeat = '0;
    logic [GW-1:0] cfg_gap = '0;
    logic          cfg_start = 1'b0, cfg_stop = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid, m_axis_tlast, busy, done;
    logic          m_axis_tready = 1'b0;
    logic [31:0]   pkt_count;

    nf10_axis_pkt_replay dut (
        .aclk(aclk), .aresetn(aresetn),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_strb(mem_wr_strb), .mem_wr_user(mem_wr_user), .mem_wr_last(mem_wr_last),
        .cfg_len(cfg_len), .cfg_repeat(cfg_repeat), .cfg_gap(cfg_gap),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done), .pkt_count(pkt_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
        int            pre_gap;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] m_data [DEPTH];
    logic [SW-1:0] m_strb [DEPTH];
    logic [UW-1:0] m_user [DEPTH];
    logic          m_last [DEPTH];

    int checks = 0, errors = 0;
    int cyc = 0, hs_cnt = 0, hs_cyc = 0, done_cnt = 0;
    int ready_mode = 0;
    int exp_pkts = 0, done_base = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd_w();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial forever begin
        @(posedge aclk);
        #1;
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom % 2);
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Monitor: hold stability, beat compare, inter-packet idle count, done timing.
    initial begin
        beat_t e;
        bit stall_prev = 0;
        int low_cnt = 0;
        logic [DW-1:0] p_data;
        logic [SW-1:0] p_strb;
        logic [UW-1:0] p_user;
        logic          p_last;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", longint'(m_axis_tvalid), 1);
                    chk_w("hold_data", m_axis_tdata, p_data);
                    chk_w("hold_strb", DW'(m_axis_tstrb), DW'(p_strb));
                    chk_w("hold_user", DW'(m_axis_tuser), DW'(p_user));
                    chk("hold_last", longint'(m_axis_tlast), longint'(p_last));
                end
                if (!m_axis_tvalid) low_cnt++;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got beat with tdata %0h, expected none", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk_w("tdata", m_axis_tdata, e.data);
                        chk_w("tstrb", DW'(m_axis_tstrb), DW'(e.strb));
                        chk_w("tuser", DW'(m_axis_tuser), DW'(e.user));
                        chk("tlast", longint'(m_axis_tlast), longint'(e.last));
                        if (e.pre_gap >= 0) chk("idle_gap", low_cnt, e.pre_gap);
                    end
                    low_cnt = 0;
                    hs_cnt++;
                    hs_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_delay", cyc - hs_cyc, 1);
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                p_data = m_axis_tdata;
                p_strb = m_axis_tstrb;
                p_user = m_axis_tuser;
                p_last = m_axis_tlast;
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic mem_write(input int addr, input logic [DW-1:0] d, input logic [SW-1:0] s,
                             input logic [UW-1:0] u, input logic l, input bit upd);
        mem_wr_en = 1'b1; mem_wr_addr = AW'(addr);
        mem_wr_data = d; mem_wr_strb = s; mem_wr_user = u; mem_wr_last = l;
        tick();
        mem_wr_en = 1'b0;
        if (upd) begin
            m_data[addr] = d; m_strb[addr] = s; m_user[addr] = u; m_last[addr] = l;
        end
    endtask

    task automatic load_prog(input int n, input logic [63:0] lastbits);
        logic [DW-1:0] u;
        for (int i = 0; i < n; i++) begin
            u = rnd_w();
            mem_write(i, rnd_w(), SW'($urandom), u[UW-1:0], lastbits[i], 1);
        end
    endtask

    // Program-level model: passes over entries 0..len-1, final entry always ends a packet.
    task automatic gen_expect(input int len, input int rep, input int gap, input int stop_k);
        beat_t e;
        int n = 0;
        bit prev_last = 0;
        exp_pkts = 0;
        forever begin
            int i = n % len;
            e.data = m_data[i]; e.strb = m_strb[i]; e.user = m_user[i];
            e.last = m_last[i] || (i == len - 1);
            e.pre_gap = (n == 0) ? -1 : (prev_last ? gap : 0);
            exp_q.push_back(e);
            n++;
            prev_last = e.last;
            if (e.last) exp_pkts++;
            if (rep > 0 && n == rep * len) break;
            if (rep == 0 && n - 1 >= stop_k && e.last) break;
        end
    endtask

    task automatic start_run(input int len, input int rep, input int gap, input int stop_k, input bit with_stop);
        gen_expect(len, rep, gap, stop_k);
        done_base = done_cnt;
        cfg_len = (AW+1)'(len); cfg_repeat = RW'(rep); cfg_gap = GW'(gap);
        cfg_start = 1'b1; cfg_stop = with_stop;
        tick();
        cfg_start = 1'b0; cfg_stop = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int budget = 0;
        while (done_cnt == done_base && budget < 4000) begin
            tick();
            budget++;
        end
        if (done_cnt == done_base) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done within 4000 cycles, expected done", tag);
        end
        repeat (5) tick();
        chk({tag, "_done_count"}, done_cnt, done_base + 1);
        chk({tag, "_beats_left"}, exp_q.size(), 0);
        chk({tag, "_pkt_count"}, longint'(pkt_count), exp_pkts);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_tvalid_idle"}, longint'(m_axis_tvalid), 0);
        exp_q.delete();
    endtask

    task automatic run(input string tag, input int len, input int rep, input int gap);
        start_run(len, rep, gap, 0, 0);
        finish_run(tag);
    endtask

    initial begin
        logic [DW-1:0] u;
        int base;
        int budget;
        repeat (3) tick();
        chk("rst_tvalid", longint'(m_axis_tvalid), 0);
        chk_w("rst_tdata", m_axis_tdata, '0);
        chk("rst_tlast", longint'(m_axis_tlast), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_pkt_count", longint'(pkt_count), 0);
        aresetn = 1'b1;
        tick();

        // Stored tlast on entries 1 and 3, full-rate then random backpressure.
        load_prog(4, 64'b1010);
        run("t1", 4, 1, 0);
        ready_mode = 1;
        run("t2", 4, 3, 0);

        // No stored tlast: final entry forces it; gap of 5 between passes.
        load_prog(3, 64'b0);
        run("t3", 3, 2, 5);

        // Continuous replay stopped mid-packet after beat 4 is presented.
        ready_mode = 0;
        load_prog(2, 64'b0);
        start_run(2, 0, 0, 4, 0);
        base = hs_cnt;
        budget = 0;
        while (hs_cnt < base + 4 && budget < 1000) begin
            tick();
            budget++;
        end
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        finish_run("t4");

        // Writes while busy are dropped; invalid lengths are ignored.
        load_prog(3, 64'b0);
        ready_mode = 1;
        start_run(3, 3, 5, 0, 0);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            u = rnd_w();
            mem_write(i, rnd_w(), SW'($urandom), u[UW-1:0], 1'b1, 0);
        end
        finish_run("t5a");
        run("t5b", 3, 1, 0);
        base = done_cnt;
        cfg_len = '0; cfg_repeat = RW'(1); cfg_start = 1'b1;
        tick();
        cfg_len = (AW+1)'(DEPTH + 1);
        tick();
        cfg_start = 1'b0;
        repeat (4) tick();
        chk("bad_len_busy", longint'(busy), 0);
        chk("bad_len_tvalid", longint'(m_axis_tvalid), 0);
        chk("bad_len_done", done_cnt, base);

        // Stop together with start in IDLE must not cut the run short.
        start_run(3, 2, 1, 0, 1);
        finish_run("t5c");

        // Boundary lengths and random programs.
        load_prog(DEPTH, {$urandom, $urandom});
        run("full_depth", DEPTH, 1, 1);
        run("len_one", 1, 3, 2);
        for (int it = 0; it < 3; it++) begin
            int ln = $urandom_range(1, 8);
            load_prog(ln, {$urandom, $urandom});
            run("rand", ln, $urandom_range(1, 3), $urandom_range(0, 4));
        end

        // Reset mid-packet under backpressure, then replay from entry 0.
        ready_mode = 2;
        load_prog(4, 64'b1010);
        cfg_len = 7'd4; cfg_repeat = '0; cfg_gap = '0; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        repeat (3) tick();
        chk("pre_rst_tvalid", longint'(m_axis_tvalid), 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rst_tvalid", longint'(m_axis_tvalid), 0);
        chk("async_rst_busy", longint'(busy), 0);
        chk("async_rst_pkt_count", longint'(pkt_count), 0);
        repeat (2) tick();
        aresetn = 1'b1;
        ready_mode = 0;
        tick();
        run("t6", 4, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
